// File: rtl/timing_pkg.sv
// Timing pulse sequencer shared types and defaults.
// State encoding plus interval-length helpers.
package timing_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        GAP   = 2'd3
    } tp_state_e;

    localparam int DEF_SETUP_CYC = 3;
    localparam int DEF_PULSE_CYC = 4;
    localparam int DEF_GAP_CYC   = 8;

    // Counter load for an interval of cyc cycles; zero acts as one.
    function automatic logic [7:0] ivl_load(input int cyc);
        logic [7:0] len;
        len = (cyc < 1) ? 8'd1 : 8'(cyc);
        return len - 8'd1;
    endfunction

endpackage

// File: rtl/timing_pulse_seq_if.sv
// Control and pulse bundle of the timing pulse sequencer.
// master drives requests, slave returns pulses and status.
interface timing_pulse_seq_if;

    logic       run_req;
    logic       single_step;
    logic       stop_req;
    logic [3:0] tp;
    logic       jk_lock;
    logic       cyc_done;
    logic       running;

    modport master (
        output run_req, single_step, stop_req,
        input  tp, jk_lock, cyc_done, running
    );

    modport slave (
        input  run_req, single_step, stop_req,
        output tp, jk_lock, cyc_done, running
    );

endinterface

// File: rtl/tp_interval_timer.sv
// 8-bit interval down-counter for the pulse sequencer.
// done is high while the count sits at zero.
module tp_interval_timer (
    input  logic       mclk,
    input  logic       clr_n,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic       done
);

    logic [7:0] count;

    // Load on request, otherwise count down and hold at zero.
    always_ff @(posedge mclk or negedge clr_n) begin
        if (!clr_n) begin
            count <= 8'd0;
        end else if (load) begin
            count <= load_val;
        end else if (count != 8'd0) begin
            count <= count - 8'd1;
        end
    end

    assign done = (count == 8'd0);

endmodule

// File: rtl/timing_pulse_seq.sv
// Four-phase time pulse sequencer (TP1..TP4) for a memory cycle.
// Outputs are registered one stage behind the state register.
module timing_pulse_seq
    import timing_pkg::*;
#(
    parameter int SETUP_CYC = DEF_SETUP_CYC,
    parameter int PULSE_CYC = DEF_PULSE_CYC,
    parameter int GAP_CYC   = DEF_GAP_CYC
) (
    input  logic               mclk,
    input  logic               clr_n,
    timing_pulse_seq_if.slave  bus
);

    localparam logic [7:0] SETUP_LD = ivl_load(SETUP_CYC);
    localparam logic [7:0] PULSE_LD = ivl_load(PULSE_CYC);
    localparam logic [7:0] GAP_LD   = ivl_load(GAP_CYC);

    tp_state_e  state_q, state_d;
    logic [1:0] phase_q, phase_d;
    logic       ss_q;
    logic       go, step;
    logic       ld;
    logic [7:0] ld_val;
    logic       ivl_done;
    logic       done_d;

    logic [3:0] tp_q;
    logic       jk_q, done_q, run_q;

    assign go   = bus.run_req & ~bus.stop_req;
    assign step = bus.single_step & ~ss_q;

    tp_interval_timer u_timer (
        .mclk     (mclk),
        .clr_n    (clr_n),
        .load     (ld),
        .load_val (ld_val),
        .done     (ivl_done)
    );

    // Next state, phase and interval load; stop only acts at cycle end.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        ld      = 1'b0;
        ld_val  = SETUP_LD;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (go || step) begin
                    state_d = SETUP;
                    phase_d = 2'd0;
                    ld      = 1'b1;
                end
            end
            SETUP: begin
                if (ivl_done) begin
                    state_d = PULSE;
                    ld      = 1'b1;
                    ld_val  = PULSE_LD;
                end
            end
            PULSE: begin
                if (ivl_done) begin
                    state_d = GAP;
                    ld      = 1'b1;
                    ld_val  = GAP_LD;
                end
            end
            GAP: begin
                if (ivl_done) begin
                    ld = 1'b1;
                    if (phase_q != 2'd3) begin
                        phase_d = phase_q + 2'd1;
                        state_d = SETUP;
                    end else begin
                        done_d  = 1'b1;
                        phase_d = 2'd0;
                        if (go) begin
                            state_d = SETUP;
                        end else begin
                            state_d = IDLE;
                            ld      = 1'b0;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, phase and single_step history registers.
    always_ff @(posedge mclk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= IDLE;
            phase_q <= 2'd0;
            ss_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            ss_q    <= bus.single_step;
        end
    end

    // Registered outputs decoded from the current state.
    always_ff @(posedge mclk or negedge clr_n) begin
        if (!clr_n) begin
            tp_q   <= 4'b0000;
            jk_q   <= 1'b0;
            done_q <= 1'b0;
            run_q  <= 1'b0;
        end else begin
            tp_q   <= (state_q == PULSE) ? (4'b0001 << phase_q)
                                         : 4'b0000;
            jk_q   <= (state_q == SETUP) || (state_q == PULSE);
            done_q <= done_d;
            run_q  <= (state_q != IDLE);
        end
    end

    assign bus.tp       = tp_q;
    assign bus.jk_lock  = jk_q;
    assign bus.cyc_done = done_q;
    assign bus.running  = run_q;

endmodule

// File: tb/tb_timing_pulse_seq.sv
// Directed bench for timing_pulse_seq: default and short-timing instances.
// Each scenario task checks its own results inline.
module tb_timing_pulse_seq;

    logic mclk;
    logic clr_n;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    timing_pulse_seq_if bus ();
    timing_pulse_seq_if bus2 ();

    timing_pulse_seq dut (
        .mclk  (mclk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    timing_pulse_seq #(
        .SETUP_CYC (2),
        .PULSE_CYC (1),
        .GAP_CYC   (0)
    ) dut2 (
        .mclk  (mclk),
        .clr_n (clr_n),
        .bus   (bus2)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    always @(posedge mclk) cyc <= cyc + 1;

    logic       sel = 1'b0;
    logic [3:0] tp_s;
    logic       jk_s, done_s, run_s;

    assign tp_s   = sel ? bus2.tp       : bus.tp;
    assign jk_s   = sel ? bus2.jk_lock  : bus.jk_lock;
    assign done_s = sel ? bus2.cyc_done : bus.cyc_done;
    assign run_s  = sel ? bus2.running  : bus.running;

    int         jk_run [2] = '{0, 0};
    logic [3:0] tp_prev [2] = '{4'b0, 4'b0};

    // Continuous pulse/jk_lock relationship checks on both instances.
    always @(posedge mclk) begin
        #1;
        for (int k = 0; k < 2; k++) begin
            logic [3:0] t;
            logic       j;
            int         su;
            t  = (k == 0) ? bus.tp : bus2.tp;
            j  = (k == 0) ? bus.jk_lock : bus2.jk_lock;
            su = (k == 0) ? 3 : 2;
            if (t != 4'b0000) begin
                n_chk++;
                if (j !== 1'b1) begin
                    n_fail++;
                    $display("FAIL jk_in_pulse dut%0d: jk=%b tp=%b, want jk=1",
                             k, j, t);
                end
                n_chk++;
                if ($countones(t) !== 1) begin
                    n_fail++;
                    $display("FAIL tp_onehot dut%0d: tp=%b, want one bit", k, t);
                end
                if (tp_prev[k] == 4'b0000) begin
                    n_chk++;
                    if (jk_run[k] !== su) begin
                        n_fail++;
                        $display("FAIL jk_before_rise dut%0d: got %0d, want %0d",
                                 k, jk_run[k], su);
                    end
                end
            end
            jk_run[k]  = (j === 1'b1) ? jk_run[k] + 1 : 0;
            tp_prev[k] = t;
        end
    end

    task automatic wait_tp(input int b, input logic lvl,
                           input int budget, output int t);
        t = -1;
        for (int i = 0; i < budget; i++) begin
            @(posedge mclk); #1;
            if (tp_s[b] === lvl) begin
                t = cyc;
                return;
            end
        end
    endtask

    task automatic wait_done(input int budget, output int t);
        t = -1;
        for (int i = 0; i < budget; i++) begin
            @(posedge mclk); #1;
            if (done_s === 1'b1) begin
                t = cyc;
                return;
            end
        end
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge mclk); #1;
            if (run_s === 1'b0) return;
        end
    endtask

    task automatic test_reset();
        clr_n = 1'b0;
        bus.run_req = 0;  bus.single_step = 0;  bus.stop_req = 0;
        bus2.run_req = 0; bus2.single_step = 0; bus2.stop_req = 0;
        repeat (2) @(posedge mclk);
        #1;
        for (int k = 0; k < 2; k++) begin
            sel = k[0];
            #1;
            n_chk++;
            if ({tp_s, jk_s, done_s, run_s} !== 7'b0) begin
                n_fail++;
                $display("FAIL reset_outs dut%0d: got %b, want 0000000",
                         k, {tp_s, jk_s, done_s, run_s});
            end
        end
        sel = 1'b0;
        clr_n = 1'b1;
        bus.run_req = 1'b1;
        @(posedge mclk); #1;
        n_chk++;
        if (run_s !== 1'b0) begin
            n_fail++;
            $display("FAIL release_edge_n: running=%b, want 0", run_s);
        end
        @(posedge mclk); #1;
        n_chk++;
        if (run_s !== 1'b1) begin
            n_fail++;
            $display("FAIL release_edge_n1: running=%b, want 1", run_s);
        end
        bus.run_req = 1'b0;
        wait_idle(100);
        n_chk++;
        if (run_s !== 1'b0) begin
            n_fail++;
            $display("FAIL release_idle: running=%b, want 0", run_s);
        end
    endtask

    task automatic test_run_continuous();
        int ts, r0, f0, r1, d1, d2, d3;
        sel = 1'b0;
        bus.run_req = 1'b1;
        @(posedge mclk); #1;
        ts = cyc;
        wait_tp(0, 1'b1, 50, r0);
        n_chk++;
        if (r0 - ts !== 4) begin
            n_fail++;
            $display("FAIL run_latency: got %0d, want 4", r0 - ts);
        end
        wait_tp(0, 1'b0, 50, f0);
        n_chk++;
        if (f0 - r0 !== 4) begin
            n_fail++;
            $display("FAIL run_width: got %0d, want 4", f0 - r0);
        end
        wait_tp(1, 1'b1, 50, r1);
        n_chk++;
        if (r1 - r0 !== 15) begin
            n_fail++;
            $display("FAIL run_spacing: got %0d, want 15", r1 - r0);
        end
        wait_done(100, d1);
        wait_done(100, d2);
        n_chk++;
        if (d2 - d1 !== 60) begin
            n_fail++;
            $display("FAIL run_cycle_len: got %0d, want 60", d2 - d1);
        end
        bus.run_req = 1'b0;
        wait_done(100, d3);
        n_chk++;
        if (d3 - d2 !== 60) begin
            n_fail++;
            $display("FAIL run_last_cycle: got %0d, want 60", d3 - d2);
        end
        wait_idle(10);
        n_chk++;
        if (run_s !== 1'b0) begin
            n_fail++;
            $display("FAIL run_idle: running=%b, want 0", run_s);
        end
    endtask

    task automatic test_single_step();
        int         nr, nd, nrun;
        logic [3:0] mask, prev;
        sel = 1'b0;
        nr = 0; nd = 0; nrun = 0; mask = 4'b0; prev = tp_s;
        bus.single_step = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge mclk); #1;
            if (i == 2)  bus.single_step = 1'b0;
            if (i == 20) bus.single_step = 1'b1;
            if (i == 22) bus.single_step = 1'b0;
            if (tp_s != 4'b0 && prev == 4'b0) begin
                nr++;
                mask |= tp_s;
            end
            prev = tp_s;
            if (done_s === 1'b1) nd++;
            if (run_s === 1'b1) nrun++;
        end
        n_chk++;
        if (nr !== 4) begin
            n_fail++;
            $display("FAIL step_pulses: got %0d, want 4", nr);
        end
        n_chk++;
        if (mask !== 4'b1111) begin
            n_fail++;
            $display("FAIL step_mask: got %b, want 1111", mask);
        end
        n_chk++;
        if (nd !== 1) begin
            n_fail++;
            $display("FAIL step_done: got %0d, want 1", nd);
        end
        n_chk++;
        if (nrun !== 60) begin
            n_fail++;
            $display("FAIL step_run_len: got %0d, want 60", nrun);
        end
        n_chk++;
        if (run_s !== 1'b0) begin
            n_fail++;
            $display("FAIL step_idle: running=%b, want 0", run_s);
        end
    endtask

    task automatic test_stop();
        int r1, f1, r2, f2, r3, f3, d, nr, nd;
        logic [3:0] prev;
        sel = 1'b0;
        bus.run_req = 1'b1;
        wait_tp(1, 1'b1, 60, r1);
        bus.stop_req = 1'b1;
        wait_tp(1, 1'b0, 20, f1);
        n_chk++;
        if (f1 - r1 !== 4) begin
            n_fail++;
            $display("FAIL stop_tp2_width: got %0d, want 4", f1 - r1);
        end
        wait_tp(2, 1'b1, 30, r2);
        wait_tp(2, 1'b0, 20, f2);
        n_chk++;
        if (f2 - r2 !== 4) begin
            n_fail++;
            $display("FAIL stop_tp3_width: got %0d, want 4", f2 - r2);
        end
        wait_tp(3, 1'b1, 30, r3);
        wait_tp(3, 1'b0, 20, f3);
        n_chk++;
        if (f3 - r3 !== 4) begin
            n_fail++;
            $display("FAIL stop_tp4_width: got %0d, want 4", f3 - r3);
        end
        wait_done(30, d);
        n_chk++;
        if (d < 0) begin
            n_fail++;
            $display("FAIL stop_done: got timeout, want cyc_done");
        end
        @(posedge mclk); #1;
        n_chk++;
        if (run_s !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_halt: running=%b, want 0", run_s);
        end
        nr = 0; nd = 0; prev = tp_s;
        for (int i = 0; i < 30; i++) begin
            @(posedge mclk); #1;
            if (tp_s != 4'b0 && prev == 4'b0) nr++;
            prev = tp_s;
            if (done_s === 1'b1) nd++;
        end
        n_chk++;
        if (nr + nd !== 0) begin
            n_fail++;
            $display("FAIL stop_quiet: got %0d events, want 0", nr + nd);
        end
        bus.run_req = 1'b0;
        bus.stop_req = 1'b0;
    endtask

    task automatic test_reset_mid_pulse();
        int r, nr, nd;
        logic [3:0] prev;
        sel = 1'b0;
        bus.single_step = 1'b1;
        @(posedge mclk); #1;
        bus.single_step = 1'b0;
        wait_tp(2, 1'b1, 80, r);
        repeat (2) begin
            @(posedge mclk); #1;
        end
        n_chk++;
        if (tp_s !== 4'b0100) begin
            n_fail++;
            $display("FAIL rst_pre_tp: got %b, want 0100", tp_s);
        end
        #2;
        clr_n = 1'b0;
        #1;
        n_chk++;
        if ({tp_s, jk_s, run_s} !== 6'b0) begin
            n_fail++;
            $display("FAIL rst_async: got %b, want 000000",
                     {tp_s, jk_s, run_s});
        end
        @(posedge mclk); #1;
        clr_n = 1'b1;
        nr = 0; nd = 0; prev = tp_s;
        for (int i = 0; i < 80; i++) begin
            @(posedge mclk); #1;
            if (tp_s != 4'b0 && prev == 4'b0) nr++;
            prev = tp_s;
            if (done_s === 1'b1) nd++;
        end
        n_chk++;
        if (nd !== 0) begin
            n_fail++;
            $display("FAIL rst_no_done: got %0d, want 0", nd);
        end
        n_chk++;
        if (nr !== 0) begin
            n_fail++;
            $display("FAIL rst_no_pulse: got %0d, want 0", nr);
        end
        n_chk++;
        if (run_s !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_idle: running=%b, want 0", run_s);
        end
    endtask

    task automatic test_short_params();
        int ts, r0, f0, r1, d1, d2, d3;
        sel = 1'b1;
        bus2.run_req = 1'b1;
        @(posedge mclk); #1;
        ts = cyc;
        wait_tp(0, 1'b1, 30, r0);
        n_chk++;
        if (r0 - ts !== 3) begin
            n_fail++;
            $display("FAIL short_latency: got %0d, want 3", r0 - ts);
        end
        wait_tp(0, 1'b0, 10, f0);
        n_chk++;
        if (f0 - r0 !== 1) begin
            n_fail++;
            $display("FAIL short_width: got %0d, want 1", f0 - r0);
        end
        wait_tp(1, 1'b1, 10, r1);
        n_chk++;
        if (r1 - r0 !== 4) begin
            n_fail++;
            $display("FAIL short_spacing: got %0d, want 4", r1 - r0);
        end
        wait_done(40, d1);
        wait_done(40, d2);
        n_chk++;
        if (d2 - d1 !== 16) begin
            n_fail++;
            $display("FAIL short_cycle_len: got %0d, want 16", d2 - d1);
        end
        bus2.run_req = 1'b0;
        wait_done(40, d3);
        n_chk++;
        if (d3 - d2 !== 16) begin
            n_fail++;
            $display("FAIL short_last_cycle: got %0d, want 16", d3 - d2);
        end
        wait_idle(10);
        n_chk++;
        if (run_s !== 1'b0) begin
            n_fail++;
            $display("FAIL short_idle: running=%b, want 0", run_s);
        end
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_run_continuous();
        test_single_step();
        test_stop();
        test_reset_mid_pulse();
        test_short_params();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/timing_pulse_seq.md
TIMING_PULSE_SEQ -- requirements
Module: timing_pulse_seq

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 3: mclk cycles J/K held stable before each pulse rises; range 2..255.
REQ-002 SHALL have parameter PULSE_CYC, default 4: mclk cycles each pulse stays high; range 1..255.
REQ-003 SHALL have parameter GAP_CYC, default 8: mclk cycles low after each pulse falls; range 1..255.
REQ-004 SHALL have port mclk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port clr_n, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port run_req, input, 1: level; keep issuing memory cycles while high.
REQ-007 SHALL have port single_step, input, 1: a rising edge while idle runs exactly one memory cycle.
REQ-008 SHALL have port stop_req, input, 1: level; halt at the next cycle boundary.
REQ-009 SHALL have port tp, output, 4: time pulses TP1..TP4, active-high; drive flip-flop clk_n inputs.
REQ-010 SHALL have port jk_lock, output, 1: high while the datapath J/K inputs must not change.
REQ-011 SHALL have port cyc_done, output, 1: one-cycle strobe when a memory cycle completes.
REQ-012 SHALL have port running, output, 1: high in any state other than IDLE.

Function
REQ-013 SHALL implement states IDLE, SETUP, PULSE and GAP, plus a 2-bit phase index (0..3).
REQ-014 IDLE SHALL go to SETUP with phase 0 when run_req=1 and stop_req=0, or when a single_step rising edge occurs; run_req wins if both occur.
REQ-015 SETUP SHALL last SETUP_CYC cycles, then go to PULSE; PULSE SHALL last PULSE_CYC cycles, then go to GAP; GAP SHALL last GAP_CYC cycles.
REQ-016 At the end of GAP with phase<3, SHALL increment phase and go to SETUP.
REQ-017 At the end of GAP with phase=3, SHALL pulse cyc_done for 1 cycle and go to SETUP with phase 0 if run_req=1 and stop_req=0, otherwise go to IDLE.
REQ-018 tp[phase] SHALL be 1 exactly during PULSE; all other tp bits SHALL be 0; at most one tp bit SHALL be high at any time.
REQ-019 jk_lock SHALL be 1 during SETUP and PULSE, and 0 in GAP and IDLE.
REQ-020 All outputs SHALL be registered, with no combinational path from inputs to outputs.
REQ-021 Latency: run_req sampled high in IDLE at edge n SHALL put the block in SETUP at n+1 and raise tp[0] at n+1+SETUP_CYC.
REQ-022 A single_step edge SHALL be detected from its registered previous value, and edges arriving while running SHALL be ignored.
REQ-023 run_req falling or stop_req rising mid-cycle SHALL NOT truncate any pulse; it only takes effect at REQ-017.
REQ-024 The interval counter SHALL be 8 bits, and a parameter value of 0 SHALL behave as 1.
REQ-025 One memory cycle SHALL take exactly 4*(SETUP_CYC+PULSE_CYC+GAP_CYC) mclk cycles.

Reset
REQ-026 clr_n=0 SHALL immediately force IDLE, phase=0, tp=0000, jk_lock=0, cyc_done=0, running=0, counter=0 and the single_step history=1.
REQ-027 Reset in mid-pulse SHALL drop tp to 0 asynchronously, and no cyc_done SHALL follow.
REQ-028 After clr_n rises, the first possible transition SHALL occur on the next mclk edge, per REQ-014.

Structure
REQ-029 The shared package timing_pkg SHALL hold the state enum and the default SETUP/PULSE/GAP constants.
REQ-030 The interval down-counter (load value, count, done flag) SHALL be a sub-module named tp_interval_timer.

Verification
REQ-031 Defaults, run_req=1 held: tp[0] rises 4 cycles after run_req is sampled, pulse widths are 4, rise-to-rise spacing is 15, and cyc_done occurs every 60 cycles.
REQ-032 run_req=0, one single_step edge: exactly 4 pulses, one cyc_done, then IDLE; a second edge while running is ignored.
REQ-033 stop_req asserted during TP2 PULSE: TP2, TP3 and TP4 complete at full width, then cyc_done, then running=0.
REQ-034 clr_n low for 1 cycle during the third cycle of TP3 PULSE: tp=0000 at once, no cyc_done, and IDLE is reached.
REQ-035 SETUP_CYC=2, PULSE_CYC=1, GAP_CYC=0: pulse width 1, spacing 4, and cycle length 16.
REQ-036 Check throughout all scenarios: jk_lock is high for every cycle where any tp bit is high, and is high exactly SETUP_CYC cycles before each rise.
